// File: rtl/riscv_pkg.sv
// Shared CPU types: register address, data word and the writeback entry
// carried from the execute/memory units to the register-file write port.
package riscv_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef logic [4:0]      reg_addr_t;
    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        reg_addr_t rd;
        word_t     data;
    } wb_entry_t;
endpackage

// File: rtl/wb_alu_fifo.sv
// Small synchronous FIFO buffering ALU results while loads own the write port.
// Pushes into a full FIFO and pops from an empty one are ignored.
module wb_alu_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t wr_entry,
    input  logic      pop,
    output wb_entry_t rd_entry,
    output logic      full,
    output logic      empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    wb_entry_t        entries_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    // Pointers wrap explicitly so depths that are not a power of two work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign full     = (count_r == CNT_W'(DEPTH));
    assign empty    = (count_r == {CNT_W{1'b0}});
    assign push_s   = push && !full;
    assign pop_s    = pop && !empty;
    assign rd_entry = entries_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
            if (pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push_s) entries_r[wr_ptr_r] <= wr_entry;
    end
endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: arbitrates load and buffered ALU results onto the registered
// register-file write port and keeps the per-register pending-write scoreboard.
module regfile_writeback
    import riscv_pkg::*;
#(
    parameter int ALU_FIFO_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    output logic      issue_ready,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    output logic      rs1_busy,
    output logic      rs2_busy,
    input  logic      alu_valid,
    input  reg_addr_t alu_rd,
    input  word_t     alu_data,
    output logic      alu_ready,
    input  logic      ld_valid,
    input  reg_addr_t ld_rd,
    input  word_t     ld_data,
    output logic      ld_ready,
    output logic      rf_we,
    output reg_addr_t rf_rd,
    output word_t     rf_wdata
);
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic             issue_fire_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             fifo_pop_s;
    wb_entry_t        fifo_head_s;
    logic             win_valid_s;
    wb_entry_t        win_entry_s;
    logic             rf_we_r;
    reg_addr_t        rf_rd_r;
    word_t            rf_wdata_r;

    assign issue_ready  = !busy_r[issue_rd];
    assign issue_fire_s = issue_valid && issue_ready && (issue_rd != 5'd0);
    assign rs1_busy     = busy_r[rs1];
    assign rs2_busy     = busy_r[rs2];
    assign alu_ready    = !fifo_full_s;
    assign ld_ready     = rst_n;
    assign rf_we        = rf_we_r;
    assign rf_rd        = rf_rd_r;
    assign rf_wdata     = rf_wdata_r;

    wb_alu_fifo #(
        .DEPTH(ALU_FIFO_DEPTH)
    ) u_alu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (alu_valid),
        .wr_entry('{rd: alu_rd, data: alu_data}),
        .pop     (fifo_pop_s),
        .rd_entry(fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Winner selection: a load always takes the port, the ALU FIFO fills gaps.
    always_comb begin
        win_valid_s = 1'b0;
        win_entry_s = '0;
        fifo_pop_s  = 1'b0;
        if (ld_valid) begin
            win_valid_s = 1'b1;
            win_entry_s = '{rd: ld_rd, data: ld_data};
        end else if (!fifo_empty_s) begin
            win_valid_s = 1'b1;
            win_entry_s = fifo_head_s;
            fifo_pop_s  = 1'b1;
        end else begin
            win_valid_s = 1'b0;
        end
    end

    // Next scoreboard: a new issue wins over a commit to the same register.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 1; i < NREGS; i++) begin
            if (issue_fire_s && (issue_rd == reg_addr_t'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (rf_we_r && (rf_rd_r == reg_addr_t'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Write-port register; x0 results are consumed without a write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_r    <= 1'b0;
            rf_rd_r    <= 5'd0;
            rf_wdata_r <= 32'd0;
        end else if (win_valid_s) begin
            rf_we_r    <= (win_entry_s.rd != 5'd0);
            rf_rd_r    <= win_entry_s.rd;
            rf_wdata_r <= win_entry_s.data;
        end else begin
            rf_we_r    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed vector table, hand-written
// back-pressure and stall/reset sequences, then randomized traffic against a model.
module tb_regfile_writeback;
    import riscv_pkg::*;

    localparam int DEPTH = 2;

    logic      clk = 1'b0;
    logic      rst_n = 1'b1;
    logic      issue_valid, issue_ready;
    reg_addr_t issue_rd, rs1, rs2;
    logic      rs1_busy, rs2_busy;
    logic      alu_valid, alu_ready;
    reg_addr_t alu_rd;
    word_t     alu_data;
    logic      ld_valid, ld_ready;
    reg_addr_t ld_rd;
    word_t     ld_data;
    logic      rf_we;
    reg_addr_t rf_rd;
    word_t     rf_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_writeback #(.ALU_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    typedef struct {
        logic      ldv;
        reg_addr_t ldrd;
        word_t     lddata;
        logic      aluv;
        reg_addr_t alurd;
        word_t     aludata;
        logic      issv;
        reg_addr_t issrd;
        reg_addr_t rs;
        logic      e_issue_ready;
        logic      e_rs_busy;
        logic      e_alu_ready;
        logic      e_we;
        logic      chk_rdw;
        reg_addr_t e_rd;
        word_t     e_wdata;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sequence A state
    wb_entry_t obs [$];
    wb_entry_t exp_wr [$];
    // Random-phase model state
    logic [31:0] mbusy;
    wb_entry_t   mq [$];
    logic        mwe;
    reg_addr_t   mrd;
    word_t       mwd;

    initial begin
        vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0};
        vecs[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[4]  = '{1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h77};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[7]  = '{1'b1, 5'd4, 32'h22,       1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h22};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h11};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h11};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[11] = '{1'b1, 5'd0, 32'h5,        1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h6,  1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};

        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_rd", rf_rd, 5'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_issue_ready", issue_ready, 1'b1);
        chk("rst_rs1_busy", rs1_busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            ld_valid = vecs[i].ldv;  ld_rd = vecs[i].ldrd;   ld_data = vecs[i].lddata;
            alu_valid = vecs[i].aluv; alu_rd = vecs[i].alurd; alu_data = vecs[i].aludata;
            issue_valid = vecs[i].issv; issue_rd = vecs[i].issrd;
            rs1 = vecs[i].rs; rs2 = vecs[i].rs;
            #1;
            chk($sformatf("v%0d_issue_ready", i), issue_ready, vecs[i].e_issue_ready);
            chk($sformatf("v%0d_rs1_busy", i), rs1_busy, vecs[i].e_rs_busy);
            chk($sformatf("v%0d_rs2_busy", i), rs2_busy, vecs[i].e_rs_busy);
            chk($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].e_alu_ready);
            chk($sformatf("v%0d_ld_ready", i), ld_ready, 1'b1);
            tick();
            chk($sformatf("v%0d_rf_we", i), rf_we, vecs[i].e_we);
            if (vecs[i].chk_rdw) begin
                chk($sformatf("v%0d_rf_rd", i), rf_rd, vecs[i].e_rd);
                chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_wdata);
            end
        end
        idle_inputs();

        // Sequence A: four back-to-back loads starve three ALU pushes (depth 2)
        begin
            int pushed;
            logic accept;
            pushed = 0;
            for (int k = 0; k < 4; k++) exp_wr.push_back('{rd: 5'(10 + k), data: 32'hB000 + 32'(k)});
            for (int k = 0; k < 3; k++) exp_wr.push_back('{rd: 5'(20 + k), data: 32'hA000 + 32'(k)});
            for (int c = 0; c < 12; c++) begin
                ld_valid = (c < 4);
                ld_rd = 5'(10 + c); ld_data = 32'hB000 + 32'(c);
                alu_valid = (pushed < 3);
                alu_rd = 5'(20 + pushed); alu_data = 32'hA000 + 32'(pushed);
                #1;
                if (c == 2) chk("bp_alu_ready_after2", alu_ready, 1'b0);
                if (c == 4) chk("bp_alu_ready_pop_full", alu_ready, 1'b0);
                if (c == 5) chk("bp_alu_ready_reopen", alu_ready, 1'b1);
                accept = alu_valid && alu_ready;
                tick();
                if (accept) pushed++;
                if (rf_we) obs.push_back('{rd: rf_rd, data: rf_wdata});
            end
            idle_inputs();
            chk("bp_write_count", obs.size(), exp_wr.size());
            for (int k = 0; k < exp_wr.size(); k++) begin
                if (k < obs.size()) begin
                    chk($sformatf("bp_w%0d_rd", k), obs[k].rd, exp_wr[k].rd);
                    chk($sformatf("bp_w%0d_data", k), obs[k].data, exp_wr[k].data);
                end
            end
        end

        // Sequence B: WAW stall on rd=9, then reset in the middle of a stall
        issue_valid = 1'b1; issue_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd9;
        #1 chk("waw_first_ready", issue_ready, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("waw_stall%0d", k), issue_ready, 1'b0);
            tick();
        end
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        #1 chk("waw_stall_ld", issue_ready, 1'b0);
        tick();
        chk("waw_ld_we", rf_we, 1'b1);
        ld_valid = 1'b0;
        #1 chk("waw_stall_commit_cycle", issue_ready, 1'b0);
        tick();
        chk("waw_ready_after_commit", issue_ready, 1'b1);
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h1212;
        ld_valid = 1'b1; ld_rd = 5'd13; ld_data = 32'h1313;
        tick();
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd9; rs1 = 5'd9;
        #1;
        chk("waw_restall", issue_ready, 1'b0);
        chk("pre_rst_we", rf_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_issue_ready", issue_ready, 1'b1);
        chk("midrst_rf_we", rf_we, 1'b0);
        chk("midrst_alu_ready", alu_ready, 1'b1);
        chk("midrst_ld_ready", ld_ready, 1'b0);
        chk("midrst_rs1_busy", rs1_busy, 1'b0);
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("postrst_no_write%0d", k), rf_we, 1'b0);
        end

        // Randomized traffic against a queue/array model
        mbusy = 32'd0; mwe = 1'b0; mrd = 5'd0; mwd = 32'd0;
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            logic e_ir;
            logic full_before;
            wb_entry_t w;
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            alu_valid = ($urandom_range(0, 2) != 0);
            alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
            ld_valid = ($urandom_range(0, 3) == 0);
            ld_rd = 5'($urandom_range(0, 7)); ld_data = $urandom;
            #1;
            e_ir = (issue_rd == 5'd0) || !mbusy[issue_rd];
            chk("rnd_issue_ready", issue_ready, e_ir);
            chk("rnd_rs1_busy", rs1_busy, mbusy[rs1]);
            chk("rnd_rs2_busy", rs2_busy, mbusy[rs2]);
            chk("rnd_alu_ready", alu_ready, mq.size() < DEPTH);
            full_before = (mq.size() >= DEPTH);
            if (mwe) mbusy[mrd] = 1'b0;
            if (issue_valid && e_ir && issue_rd != 5'd0) mbusy[issue_rd] = 1'b1;
            if (ld_valid) begin
                mwe = (ld_rd != 5'd0); mrd = ld_rd; mwd = ld_data;
            end else if (mq.size() > 0) begin
                w = mq.pop_front();
                mwe = (w.rd != 5'd0); mrd = w.rd; mwd = w.data;
            end else begin
                mwe = 1'b0;
            end
            if (alu_valid && !full_before) mq.push_back('{rd: alu_rd, data: alu_data});
            tick();
            chk("rnd_rf_we", rf_we, mwe);
            if (mwe) begin
                chk("rnd_rf_rd", rf_rd, mrd);
                chk("rnd_rf_wdata", rf_wdata, mwd);
            end
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback stage and scoreboard that drives the write port of the CPU register file. It accepts results from the single-cycle ALU path and the multi-cycle load unit, arbitrates them onto the single registered write port (`we`/`rd`/`wdata`), and tracks pending destinations so decode can detect RAW/WAW hazards. It sits between the execute/memory units and `regfile`.

## Interface

Parameters:

- `ALU_FIFO_DEPTH`, default 2: ALU result buffer entries, ≥2.

Ports:

- `clk`  in  1  clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `issue_valid`  in  1  decode issues an instruction writing `issue_rd`
- `issue_rd`  in  reg_addr_t  destination of issued instruction
- `issue_ready`  out  1  issue accepted when `issue_valid && issue_ready`
- `rs1`, `rs2`  in  reg_addr_t  decode source operands
- `rs1_busy`, `rs2_busy`  out  1  source has a pending write
- `alu_valid`  in  1  ALU result valid
- `alu_rd`  in  reg_addr_t  ALU destination
- `alu_data`  in  word_t  ALU result
- `alu_ready`  out  1  ALU result accepted on `alu_valid && alu_ready`
- `ld_valid`  in  1  load response valid
- `ld_rd`  in  reg_addr_t  load destination
- `ld_data`  in  word_t  load data
- `ld_ready`  out  1  load accepted on `ld_valid && ld_ready`
- `rf_we`  out  1  register-file write enable (registered)
- `rf_rd`  out  reg_addr_t  write address (registered)
- `rf_wdata`  out  word_t  write data (registered)

## Operation

- Scoreboard: 32 busy bits, bit 0 constant 0. Accepted issue with `issue_rd != 0` sets `busy[issue_rd]`.
- `issue_ready = !busy[issue_rd]`, which stalls WAW. `rd == 0` is always ready.
- `rs1_busy = busy[rs1]`, `rs2_busy = busy[rs2]`, combinational from registered bits.
- ALU results are pushed into the FIFO. `alu_ready = !full`. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- `ld_ready = 1` whenever `rst_n` is high. A load is never back-pressured.
- Arbitration per cycle:
  - `ld_valid` wins the output register.
  - Otherwise the FIFO head pops, if the FIFO is non-empty.
  - The ALU starves while loads are continuous; this is accepted.
- Output register loads the winner:
  - `rf_we = 1` if the winner's `rd != 0`.
  - A winner with `rd == 0` is consumed with `rf_we = 0`.
  - No winner gives `rf_we = 0`; `rf_rd`/`rf_wdata` hold their previous values.
- Busy clear: on each edge where `rf_we` is 1, `busy[rf_rd]` clears. This is the same edge on which `regfile` commits the data.
- Set and clear of the same index on one edge cannot occur, because issue is stalled while busy. If it occurs anyway, set wins.
- Writes arriving for a non-busy register are still written. The scoreboard bit stays 0.

## Timing

- Reset (async assert, sync release):
  - `rf_we = 0`, `rf_rd = 0`, `rf_wdata = 0`.
  - All busy bits 0, FIFO empty.
  - `alu_ready = 1`, `ld_ready = 0` while in reset.
  - `issue_ready = 1`, `rs*_busy = 0`.
- Load latency: accepted at edge E0 → `rf_we` high after E0 → regfile write and busy clear at E1 → `rs*_busy` low after E1.
- ALU latency, uncontended: pushed at E0 → popped into the output register at E1 → committed at E2.
- Issue to `rd` busy-clearing at edge E: `issue_ready` is 0 before E and 1 after E.
- Reset mid-operation discards FIFO contents, clears busy bits, and drops any pending `rf_we` immediately.

## Structure

- `reg_addr_t` and `word_t` come from `riscv_pkg`.
- Add a `wb_entry_t` struct (`rd`, `data`) to `riscv_pkg`.
- Sub-module `wb_alu_fifo`: synchronous FIFO of `wb_entry_t`, depth `ALU_FIFO_DEPTH`, with full/empty outputs, push/pop, and async active-low reset.
- Scoreboard, arbiter and output register live in `regfile_writeback`.

## Test plan

- Reset, then load `rd=5`, data `0xDEADBEEF` at E0 → `rf_we=1`, `rf_rd=5`, `rf_wdata=0xDEADBEEF` in the next cycle only.
- Issue `rd=7`, then probe `rs1=7` → `rs1_busy=1`. A load to `rd=7` lands → `rs1_busy=0` exactly one edge after `rf_we` is seen.
- ALU `rd=3`, data `0x11` and load `rd=4`, data `0x22` valid in the same cycle → load written first, ALU (`rf_rd=3`) one cycle later.
- Hold `ld_valid` for 4 cycles while the ALU pushes 3 results with depth 2 → `alu_ready` drops after 2 pushes. All 3 ALU results are written in order after the loads end; none are lost.
- Issue `rd=0`, then load/ALU result to `rd=0` → `issue_ready=1`, `rs1_busy` for `rs1=0` stays 0, `rf_we` stays 0.
- Issue `rd=9` and hold a second `issue_valid` with `rd=9` → `issue_ready=0` until the write of `rd=9` commits. Assert `rst_n=0` mid-stall → `issue_ready=1`, FIFO empty, `rf_we=0` immediately.
